// File: rtl/bcd_step_counter_if.sv
// Button, load and digit signals of the BCD step counter.
// The master side drives buttons/load; the slave side is the counter itself.
interface bcd_step_counter_if;
  logic       btn_run;
  logic       btn_dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] bcd;
  logic       carry;
  logic       running;
  logic       dir;

  modport master (
    output btn_run, btn_dir, load, load_val,
    input  bcd, carry, running, dir
  );

  modport slave (
    input  btn_run, btn_dir, load, load_val,
    output bcd, carry, running, dir
  );
endinterface

// File: rtl/bcd_step_counter.sv
// Single-digit BCD up/down counter with debounced run/pause and direction buttons,
// a free-running step prescaler while running, and a synchronous preset load.
//
// state   | meaning
// --------+---------------------------------------------
// S_PAUSE | digit frozen, prescaler held at 0
// S_RUN   | prescaler counts, digit steps on terminal count
module bcd_step_counter #(
  parameter int                   DIV_WIDTH = 24,
  parameter logic [DIV_WIDTH-1:0] DIV_TERM  = DIV_WIDTH'(9_999_999),
  parameter int                   DEB_LEN   = 4
) (
  input logic               clk,
  input logic               rst_n,
  bcd_step_counter_if.slave bus
);

  typedef enum logic {
    S_PAUSE = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  // Index 0 is the run button, index 1 the direction button.
  logic [1:0][DEB_LEN-1:0] sh_q, sh_d;
  logic [1:0]              deb_q, deb_d;
  logic [1:0]              dly_q;
  logic [1:0]              raw;
  logic [1:0]              pulse;

  state_e                  state_q, state_d;
  logic [DIV_WIDTH-1:0]    pre_q, pre_d;
  logic                    dir_q, dir_d;
  logic [3:0]              bcd_q, bcd_d;
  logic                    carry_q, carry_d;
  logic                    step;
  logic                    load_ok;

  assign raw   = {bus.btn_dir, bus.btn_run};
  assign pulse = deb_q & ~dly_q;

  // Level only moves once the whole sample window agrees.
  always_comb begin
    sh_d  = sh_q;
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      sh_d[i] = {sh_q[i][DEB_LEN-2:0], raw[i]};
      if (&sh_q[i]) begin
        deb_d[i] = 1'b1;
      end else if (~|sh_q[i]) begin
        deb_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (pulse[0]) begin
      state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
    end
  end

  assign step = (state_q == S_RUN) && (pre_q == DIV_TERM);

  // Entering or leaving RUN restarts the period from zero.
  always_comb begin
    pre_d = '0;
    if ((state_q == S_RUN) && (state_d == S_RUN)) begin
      pre_d = step ? '0 : pre_q + DIV_WIDTH'(1);
    end
  end

  assign dir_d   = dir_q ^ pulse[1];
  assign load_ok = bus.load && (bus.load_val <= 4'd9);

  // A valid load wins over a step; the step then uses the pre-toggle direction.
  always_comb begin
    bcd_d   = bcd_q;
    carry_d = 1'b0;
    if (load_ok) begin
      bcd_d = bus.load_val;
    end else if (step) begin
      if (!dir_q) begin
        if (bcd_q >= 4'd9) begin
          bcd_d   = 4'd0;
          carry_d = 1'b1;
        end else begin
          bcd_d = bcd_q + 4'd1;
        end
      end else begin
        if (bcd_q == 4'd0) begin
          bcd_d   = 4'd9;
          carry_d = 1'b1;
        end else begin
          bcd_d = bcd_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q    <= '0;
      deb_q   <= '0;
      dly_q   <= '0;
      state_q <= S_PAUSE;
      pre_q   <= '0;
      dir_q   <= 1'b0;
      bcd_q   <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      deb_q   <= deb_d;
      dly_q   <= deb_q;
      state_q <= state_d;
      pre_q   <= pre_d;
      dir_q   <= dir_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
    end
  end

  assign bus.bcd     = bcd_q;
  assign bus.carry   = carry_q;
  assign bus.running = (state_q == S_RUN);
  assign bus.dir     = dir_q;

endmodule
